// File: rtl/vpu3_top.sv
// vpu3_top: start/done-controlled vector engine. Streams LEN elements from the
// operand RAMs through N_CH independent modular lanes (one per RNS limb) and
// writes the results back. Every mode (MUL, MAC, ADD, SUB) has the same latency.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_start           job request, honoured only when idle and i_len != 0
//   i_mode            0 MUL, 1 MAC, 2 ADD, 3 SUB (latched at start)
//   i_len             element count 1..2^AW (latched at start)
//   i_rd_base         read base address (latched at start)
//   i_wr_base         write base address (latched at start)
//   o_done            high while idle
//   i_din             operand a, channel k at [k*DW +: DW]
//   i_extdin          per channel {c,b}: b at [2k*DW +: DW], c at [(2k+1)*DW +: DW]
//   o_rden, o_rdaddr  operand read request
//   o_wren, o_wraddr  result write request
//   o_dout            result, same packing as i_din
module vpu3_top #(
    parameter int                 N_CH     = 3,
    parameter int                 DW       = 39,
    parameter logic [N_CH*DW-1:0] MODS     = {39'h40_0080_0001, 39'h04_0800_0001, 39'h04_0008_0001},
    parameter int                 AW       = 12,
    parameter int                 RD_DELAY = 4,
    parameter int                 DP_DELAY = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_start,
    input  logic [1:0]             i_mode,
    input  logic [AW:0]            i_len,
    input  logic [AW-1:0]          i_rd_base,
    input  logic [AW-1:0]          i_wr_base,
    output logic                   o_done,
    input  logic [N_CH*DW-1:0]     i_din,
    input  logic [2*N_CH*DW-1:0]   i_extdin,
    output logic                   o_rden,
    output logic [AW-1:0]          o_rdaddr,
    output logic                   o_wren,
    output logic [AW-1:0]          o_wraddr,
    output logic [N_CH*DW-1:0]     o_dout
);

    localparam int W  = RD_DELAY + DP_DELAY;
    // count must reach W + 2^AW - 1
    localparam int CW = $clog2((2**AW) + W + 1);
    localparam logic [CW-1:0] W_C = CW'(W);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   count;
    logic [1:0]      mode;
    logic [AW:0]     len;
    logic [AW-1:0]   rd_base, wr_base;
    logic [CW-1:0]   len_c;
    logic            start_ok, last_wr, busy;

    assign len_c    = CW'(len);
    assign busy     = (state == BUSY);
    assign start_ok = (state == IDLE) && i_start && (i_len != '0);
    assign last_wr  = (count == W_C + len_c - CW'(1));

    // ---------------- modular arithmetic helpers ----------------
    function automatic logic [DW-1:0] mod_reduce(input logic [2*DW:0] x, input logic [DW-1:0] q);
        return DW'(x % {{(DW+1){1'b0}}, q});
    endfunction

    // s < 2q, so one conditional subtraction is exact
    function automatic logic [DW-1:0] add_reduce(input logic [DW:0] s, input logic [DW-1:0] q);
        return (s >= {1'b0, q}) ? DW'(s - {1'b0, q}) : DW'(s);
    endfunction

    function automatic logic [DW-1:0] lane_op(input logic [1:0] m, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b, input logic [DW-1:0] c,
                                              input logic [DW-1:0] q);
        logic [2*DW:0] prod;
        prod = (2*DW+1)'(a) * (2*DW+1)'(b);
        case (m)
            2'd0:    return mod_reduce(prod, q);
            2'd1:    return mod_reduce(prod + (2*DW+1)'(c), q);
            2'd2:    return add_reduce({1'b0, a} + {1'b0, c}, q);
            default: return add_reduce({1'b0, a} + {1'b0, q} - {1'b0, c}, q);
        endcase
    endfunction

    // ---------------- control: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // ---------------- control: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = BUSY;
            BUSY:    if (last_wr)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- control: outputs ----------------
    always_comb begin
        o_done   = (state == IDLE);
        o_rden   = busy && (count < len_c);
        o_rdaddr = busy ? (rd_base + AW'(count)) : '0;
        o_wren   = busy && (count >= W_C) && (count < W_C + len_c);
        o_wraddr = o_wren ? (wr_base + AW'(count - W_C)) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                count <= '0;
        else if (busy && !last_wr) count <= count + CW'(1);
        else                       count <= '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode    <= '0;
            len     <= '0;
            rd_base <= '0;
            wr_base <= '0;
        end else if (start_ok) begin
            mode    <= i_mode;
            len     <= i_len;
            rd_base <= i_rd_base;
            wr_base <= i_wr_base;
        end
    end

    // ---------------- read latency: valid follows o_rden ----------------
    logic [RD_DELAY-1:0] vld_rd;
    logic                vld_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_rd <= '0;
        else begin
            vld_rd[0] <= o_rden;
            for (int i = 1; i < RD_DELAY; i++) vld_rd[i] <= vld_rd[i-1];
        end
    end
    assign vld_in = vld_rd[RD_DELAY-1];

    // ---------------- lane arithmetic on sampled operands ----------------
    logic [N_CH*DW-1:0] res_c;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        localparam logic [DW-1:0] Q = MODS[k*DW +: DW];
        assign res_c[k*DW +: DW] = lane_op(mode, i_din[k*DW +: DW],
                                           i_extdin[2*k*DW +: DW],
                                           i_extdin[(2*k+1)*DW +: DW], Q);
    end

    // ---------------- datapath stages: DP_DELAY registers ----------------
    logic [DP_DELAY-1:0] vld_p;
    logic [N_CH*DW-1:0]  res_p [DP_DELAY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_p <= '0;
        else begin
            vld_p[0] <= vld_in;
            for (int i = 1; i < DP_DELAY; i++) vld_p[i] <= vld_p[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (vld_in) res_p[0] <= res_c;
        for (int i = 1; i < DP_DELAY; i++)
            if (vld_p[i-1]) res_p[i] <= res_p[i-1];
    end

    assign o_dout = res_p[DP_DELAY-1];

endmodule
